// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
//   Turns debounced keypad codes into a two-operand entry transaction for the
//   calculator datapath. Each physical press is taken exactly once. The key
//   must then be released for RELEASE_CYC consecutive no-key cycles before
//   another press is accepted. Two BCD operands are built up digit by digit.
//   '+' moves from operand A to operand B. '#' completes the entry and strobes
//   op_valid. '*' clears the entry.
//
// Optional feature (compile-time macro KEY_BACKSPACE_EN):
//   When the macro is defined, key C acts as backspace on the operand being
//   entered. When it is not defined, key C is accepted but has no effect.
//
// Parameters:
//   DIGITS       max BCD digits per operand (operand width 4*DIGITS)
//   RELEASE_CYC  consecutive no-key cycles needed to re-arm after a press
//
// Ports:
//   clk          system clock
//   n_reset      asynchronous active-low reset
//   key_code     decoded key: 0-9 digit, A '+', D '*' clear, E '#' enter, F none
//   key_accept   one-cycle pulse after the edge a key is taken
//   operand_a    BCD operand A, least significant digit in [3:0]
//   operand_b    BCD operand B
//   op_valid     one-cycle pulse, aligned with key_accept; operands are final
//   display      operand currently shown (A in S_A, B otherwise)
//   entry_state  00 = S_A, 01 = S_B, 10 = S_DONE
//   digit_cnt    digits entered so far in the operand being edited
module keypad_entry_ctrl #(
    parameter int DIGITS      = 3,
    parameter int RELEASE_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         n_reset,
    input  logic [3:0]                   key_code,
    output logic                         key_accept,
    output logic [4*DIGITS-1:0]          operand_a,
    output logic [4*DIGITS-1:0]          operand_b,
    output logic                         op_valid,
    output logic [4*DIGITS-1:0]          display,
    output logic [1:0]                   entry_state,
    output logic [$clog2(DIGITS+1)-1:0]  digit_cnt
);

    localparam int OW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int RW = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
    localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYC - 1);

    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic [3:0] KEY_PLUS = 4'hA;
    localparam logic [3:0] KEY_CLR  = 4'hD;
    localparam logic [3:0] KEY_ENT  = 4'hE;
`ifdef KEY_BACKSPACE_EN
    localparam logic [3:0] KEY_BS   = 4'hC;
`endif

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          armed;
    logic [RW-1:0] rel_cnt;
    logic          take;
    logic          is_digit;
    logic [OW-1:0] a_nxt;
    logic [OW-1:0] b_nxt;
    logic [CW-1:0] cnt_nxt;

    // New digit enters at the least significant position.
    function automatic logic [OW-1:0] shift_in(input logic [OW-1:0] op,
                                               input logic [3:0]    d);
        shift_in = (op << 4) | OW'(d);
    endfunction

`ifdef KEY_BACKSPACE_EN
    // Drop the least significant digit and fill the top digit with zero.
    function automatic logic [OW-1:0] shift_out(input logic [OW-1:0] op);
        shift_out = op >> 4;
    endfunction
`endif

    assign take     = armed && (key_code != KEY_NONE);
    assign is_digit = (key_code <= 4'd9);

    // Press/release qualification. Any key cycle restarts the release count,
    // so a key that is held down can never re-arm the controller. The count
    // saturates at its last value while the keypad stays idle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            armed   <= 1'b1;
            rel_cnt <= '0;
        end else if (key_code != KEY_NONE) begin
            rel_cnt <= '0;
            if (take) begin
                armed <= 1'b0;
            end
        end else if (rel_cnt == REL_LAST) begin
            armed <= 1'b1;
        end else begin
            rel_cnt <= rel_cnt + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= S_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (take) begin
            if (key_code == KEY_CLR) begin
                state_nxt = S_A;
            end else begin
                case (state)
                    S_A:    if (key_code == KEY_PLUS) state_nxt = S_B;
                    S_B:    if (key_code == KEY_ENT)  state_nxt = S_DONE;
                    S_DONE: if (is_digit)             state_nxt = S_A;
                    default:                          state_nxt = S_A;
                endcase
            end
        end
    end

    // State-derived outputs
    always_comb begin
        entry_state = state;
        display     = (state == S_A) ? operand_a : operand_b;
    end

    // Operand and digit-count update for the accepted key
    always_comb begin
        a_nxt   = operand_a;
        b_nxt   = operand_b;
        cnt_nxt = digit_cnt;
        if (take) begin
            if (key_code == KEY_CLR) begin
                a_nxt   = '0;
                b_nxt   = '0;
                cnt_nxt = '0;
            end else if (is_digit) begin
                if (state == S_DONE) begin
                    // A digit after a completed entry starts a new operand A.
                    a_nxt   = OW'(key_code);
                    b_nxt   = '0;
                    cnt_nxt = CW'(1);
                end else if (digit_cnt < CNT_FULL) begin
                    if (state == S_A) begin
                        a_nxt = shift_in(operand_a, key_code);
                    end else begin
                        b_nxt = shift_in(operand_b, key_code);
                    end
                    cnt_nxt = digit_cnt + 1'b1;
                end
            end else if (key_code == KEY_PLUS && state == S_A) begin
                cnt_nxt = '0;
`ifdef KEY_BACKSPACE_EN
            end else if (key_code == KEY_BS && state != S_DONE &&
                         digit_cnt != '0) begin
                if (state == S_A) begin
                    a_nxt = shift_out(operand_a);
                end else begin
                    b_nxt = shift_out(operand_b);
                end
                cnt_nxt = digit_cnt - 1'b1;
`endif
            end
        end
    end

    // Operand, digit-count and strobe registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            operand_a  <= '0;
            operand_b  <= '0;
            digit_cnt  <= '0;
            key_accept <= 1'b0;
            op_valid   <= 1'b0;
        end else begin
            operand_a  <= a_nxt;
            operand_b  <= b_nxt;
            digit_cnt  <= cnt_nxt;
            key_accept <= take;
            op_valid   <= take && (key_code == KEY_ENT) && (state == S_B);
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl. A table of key presses, each followed
// by a release interval, with the expected outputs after each one. Hand-written
// sequences cover reset, asynchronous reset in the middle of an entry, and
// acceptance on the first edge after reset.
module tb_keypad_entry_ctrl;

    localparam int RC = 1024;

`ifdef KEY_BACKSPACE_EN
    localparam bit BS = 1'b1;
`else
    localparam bit BS = 1'b0;
`endif

    logic        clk;
    logic        n_reset;
    logic [3:0]  key_code;
    logic        key_accept;
    logic [11:0] operand_a;
    logic [11:0] operand_b;
    logic        op_valid;
    logic [11:0] display;
    logic [1:0]  entry_state;
    logic [1:0]  digit_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    keypad_entry_ctrl #(.DIGITS(3), .RELEASE_CYC(RC)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .key_code    (key_code),
        .key_accept  (key_accept),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .op_valid    (op_valid),
        .display     (display),
        .entry_state (entry_state),
        .digit_cnt   (digit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  key;
        int          hold;
        int          rel;
        int          acc;
        int          ov;
        logic [11:0] a;
        logic [11:0] b;
        logic [1:0]  st;
        logic [1:0]  cnt;
        logic [11:0] disp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] key, input int hold, input int rel,
                       input int acc, input int ov, input logic [11:0] a,
                       input logic [11:0] b, input logic [1:0] st,
                       input logic [1:0] cnt, input logic [11:0] disp);
        vec_t v;
        v.key = key; v.hold = hold; v.rel = rel; v.acc = acc; v.ov = ov;
        v.a = a; v.b = b; v.st = st; v.cnt = cnt; v.disp = disp;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Entered and left on a falling edge. Pulses are counted over the whole
    // hold and release window. op_valid outside a key_accept cycle is
    // recorded as a misalignment.
    task automatic press(input logic [3:0] k, input int hold, input int rel,
                         output int acc, output int ov, output int mis);
        acc = 0; ov = 0; mis = 0;
        key_code = k;
        for (int i = 0; i < hold + rel; i++) begin
            if (i == hold) key_code = 4'hF;
            @(negedge clk);
            acc += int'(key_accept);
            ov  += int'(op_valid);
            if (op_valid && !key_accept) mis++;
        end
    endtask

    initial begin
        int acc, ov, mis;
        logic [11:0] bs_a1, bs_a0, bs_b;
        logic [1:0]  bs_c1, bs_c0, bs_cb;

        n_reset  = 1'b0;
        key_code = 4'hF;

        // Expected operand / count after the backspace presses.
        bs_a1 = BS ? 12'h001 : 12'h012;  bs_c1 = BS ? 2'd1 : 2'd2;
        bs_a0 = BS ? 12'h000 : 12'h012;  bs_c0 = BS ? 2'd0 : 2'd2;
        bs_b  = BS ? 12'h000 : 12'h003;  bs_cb = BS ? 2'd0 : 2'd1;

        //   key    hold  rel acc ov  a        b        st     cnt    disp
        add(4'h1,   50,   RC, 1, 0, 12'h001, 12'h000, 2'b00, 2'd1, 12'h001);
        add(4'h2,   50,   RC, 1, 0, 12'h012, 12'h000, 2'b00, 2'd2, 12'h012);
        add(4'h3,   50,   RC, 1, 0, 12'h123, 12'h000, 2'b00, 2'd3, 12'h123);
        add(4'h4,   50,   RC, 1, 0, 12'h123, 12'h000, 2'b00, 2'd3, 12'h123);
        add(4'hD,   50,   RC, 1, 0, 12'h000, 12'h000, 2'b00, 2'd0, 12'h000);
        add(4'h5,   5000, 100, 1, 0, 12'h005, 12'h000, 2'b00, 2'd1, 12'h005);
        add(4'h6,   50,   RC, 0, 0, 12'h005, 12'h000, 2'b00, 2'd1, 12'h005);
        add(4'hD,   50,   RC, 1, 0, 12'h000, 12'h000, 2'b00, 2'd0, 12'h000);
        add(4'h4,   50,   RC, 1, 0, 12'h004, 12'h000, 2'b00, 2'd1, 12'h004);
        add(4'h7,   50,   RC, 1, 0, 12'h047, 12'h000, 2'b00, 2'd2, 12'h047);
        add(4'hA,   50,   RC, 1, 0, 12'h047, 12'h000, 2'b01, 2'd0, 12'h000);
        add(4'h9,   50,   RC, 1, 0, 12'h047, 12'h009, 2'b01, 2'd1, 12'h009);
        add(4'hA,   50,   RC, 1, 0, 12'h047, 12'h009, 2'b01, 2'd1, 12'h009);
        add(4'hE,   50,   RC, 1, 1, 12'h047, 12'h009, 2'b10, 2'd1, 12'h009);
        add(4'hE,   50,   RC, 1, 0, 12'h047, 12'h009, 2'b10, 2'd1, 12'h009);
        add(4'hA,   50,   RC, 1, 0, 12'h047, 12'h009, 2'b10, 2'd1, 12'h009);
        add(4'h8,   50,   RC, 1, 0, 12'h008, 12'h000, 2'b00, 2'd1, 12'h008);
        add(4'hB,   50,   RC, 1, 0, 12'h008, 12'h000, 2'b00, 2'd1, 12'h008);
        add(4'hD,   50,   RC, 1, 0, 12'h000, 12'h000, 2'b00, 2'd0, 12'h000);
        add(4'h1,   50,   RC, 1, 0, 12'h001, 12'h000, 2'b00, 2'd1, 12'h001);
        add(4'h2,   50,   RC, 1, 0, 12'h012, 12'h000, 2'b00, 2'd2, 12'h012);
        add(4'hC,   50,   RC, 1, 0, bs_a1,   12'h000, 2'b00, bs_c1, bs_a1);
        add(4'hC,   50,   RC, 1, 0, bs_a0,   12'h000, 2'b00, bs_c0, bs_a0);
        add(4'hC,   50,   RC, 1, 0, bs_a0,   12'h000, 2'b00, bs_c0, bs_a0);
        add(4'hA,   50,   RC, 1, 0, bs_a0,   12'h000, 2'b01, 2'd0, 12'h000);
        add(4'h3,   50,   RC, 1, 0, bs_a0,   12'h003, 2'b01, 2'd1, 12'h003);
        add(4'hC,   50,   RC, 1, 0, bs_a0,   bs_b,    2'b01, bs_cb, bs_b);
        add(4'hE,   50,   RC, 1, 1, bs_a0,   bs_b,    2'b10, bs_cb, bs_b);
        add(4'hC,   50,   RC, 1, 0, bs_a0,   bs_b,    2'b10, bs_cb, bs_b);
        add(4'hD,   50,   RC, 1, 0, 12'h000, 12'h000, 2'b00, 2'd0, 12'h000);
        add(4'hA,   50,   RC, 1, 0, 12'h000, 12'h000, 2'b01, 2'd0, 12'h000);
        add(4'hE,   50,   RC, 1, 1, 12'h000, 12'h000, 2'b10, 2'd0, 12'h000);
        add(4'hD,   50,   RC, 1, 0, 12'h000, 12'h000, 2'b00, 2'd0, 12'h000);

        // Outputs while held in reset
        repeat (3) @(negedge clk);
        check("rst.key_accept", key_accept, 0);
        check("rst.op_valid",   op_valid,   0);
        check("rst.operand_a",  operand_a,  0);
        check("rst.operand_b",  operand_b,  0);
        check("rst.state",      entry_state, 2'b00);
        check("rst.digit_cnt",  digit_cnt,  0);
        check("rst.display",    display,    0);
        n_reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            press(vecs[i].key, vecs[i].hold, vecs[i].rel, acc, ov, mis);
            check($sformatf("v%0d.accepts", i),   acc,         vecs[i].acc);
            check($sformatf("v%0d.op_valids", i), ov,          vecs[i].ov);
            check($sformatf("v%0d.ov_align", i),  mis,         0);
            check($sformatf("v%0d.operand_a", i), operand_a,   vecs[i].a);
            check($sformatf("v%0d.operand_b", i), operand_b,   vecs[i].b);
            check($sformatf("v%0d.state", i),     entry_state, vecs[i].st);
            check($sformatf("v%0d.digit_cnt", i), digit_cnt,   vecs[i].cnt);
            check($sformatf("v%0d.display", i),   display,     vecs[i].disp);
        end

        // Asynchronous reset part-way through an entry.
        press(4'h1, 50, RC, acc, ov, mis);
        key_code = 4'h2;
        @(negedge clk);
        check("mid.pre_a",      operand_a,  12'h012);
        check("mid.pre_accept", key_accept, 1);
        #2 n_reset = 1'b0;
        #1;
        check("mid.key_accept", key_accept, 0);
        check("mid.operand_a",  operand_a,  0);
        check("mid.operand_b",  operand_b,  0);
        check("mid.digit_cnt",  digit_cnt,  0);
        check("mid.state",      entry_state, 2'b00);
        check("mid.display",    display,    0);

        // Key 2 is still held. Armed resets to 1, so the first edge after
        // reset takes the key.
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check("post.key_accept", key_accept, 1);
        check("post.operand_a",  operand_a,  12'h002);
        check("post.digit_cnt",  digit_cnt,  1);
        @(negedge clk);
        check("post.accept_drop", key_accept, 0);
        check("post.no_repeat_a", operand_a,  12'h002);
        key_code = 4'hF;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
